ascon_permutation: RTL and testbench

ASCON_PERMUTATION -- requirements
Module: ascon_permutation

---
 rtl/ascon_permutation.sv | 106 ++++++++++
 tb/tb_ascon_permutation.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation.sv
// ascon_permutation: iterative Ascon permutation, one round per clock, start-edge launched
// Ports: iClk clock; iReset_n async active-low reset; start level request (rising edge launches);
//        x0..x4 initial state words; x0_o..x4_o registered result; oBusy high while rounds run;
//        oDone high while a finished result is held and start stays high
module ascon_permutation #(
    parameter int ROUNDS = 12
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        start,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        oBusy,
    output logic        oDone
);
    typedef logic [4:0][63:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t       state, nextState;
    state_t     s, res, rnd;
    logic [3:0] r;
    logic       startD, launch;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        ror = 64'({v, v} >> n);
    endfunction

    function automatic state_t roundFn(input state_t a, input logic [3:0] rc);
        state_t t;
        a[2] = a[2] ^ {56'b0, 4'hF - rc, rc};
        a[0] = a[0] ^ a[4];
        a[4] = a[4] ^ a[3];
        a[2] = a[2] ^ a[1];
        t[0] = ~a[0] & a[1];
        t[1] = ~a[1] & a[2];
        t[2] = ~a[2] & a[3];
        t[3] = ~a[3] & a[4];
        t[4] = ~a[4] & a[0];
        a[0] = a[0] ^ t[1];
        a[1] = a[1] ^ t[2];
        a[2] = a[2] ^ t[3];
        a[3] = a[3] ^ t[4];
        a[4] = a[4] ^ t[0];
        a[1] = a[1] ^ a[0];
        a[0] = a[0] ^ a[4];
        a[3] = a[3] ^ a[2];
        a[2] = ~a[2];
        a[0] = a[0] ^ ror(a[0], 19) ^ ror(a[0], 28);
        a[1] = a[1] ^ ror(a[1], 61) ^ ror(a[1], 39);
        a[2] = a[2] ^ ror(a[2], 1) ^ ror(a[2], 6);
        a[3] = a[3] ^ ror(a[3], 10) ^ ror(a[3], 17);
        a[4] = a[4] ^ ror(a[4], 7) ^ ror(a[4], 41);
        return a;
    endfunction

    assign launch = start & ~startD;
    assign rnd    = roundFn(s, r);

    // round index 11 is always the last, so shorter permutations start later in the schedule
    always_comb begin
        nextState = (state == IDLE && launch)   ? RUN  :
                    (state == RUN && r == 4'd11) ? DONE :
                    (state == DONE && !start)    ? IDLE : state;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state  <= IDLE;
            startD <= 1'b0;
        end else begin
            state  <= nextState;
            startD <= start;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            s   <= '0;
            r   <= '0;
            res <= '0;
        end else if (state == IDLE && launch) begin
            s <= {x4, x3, x2, x1, x0};
            r <= 4'(12 - ROUNDS);
        end else if (state == RUN) begin
            s <= rnd;
            r <= r + 4'd1;
            if (r == 4'd11) res <= rnd;
        end
    end

    assign x0_o  = res[0];
    assign x1_o  = res[1];
    assign x2_o  = res[2];
    assign x3_o  = res[3];
    assign x4_o  = res[4];
    assign oBusy = (state == RUN);
    assign oDone = (state == DONE);
endmodule

// File: tb/tb_ascon_permutation.sv
// tb_ascon_permutation: directed checks of ascon_permutation with ROUNDS=1 and ROUNDS=12 instances
module tb_ascon_permutation;
    typedef logic [4:0][63:0] state_t;

    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                         5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                         5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                         5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    logic   iClk, iReset_n, start1, start12;
    logic   busy1, done1, busy12, done12;
    state_t in1, in12, out1, out12;
    int     checks = 0;
    int     errors = 0;

    ascon_permutation #(.ROUNDS(1)) dut1 (
        .iClk(iClk), .iReset_n(iReset_n), .start(start1),
        .x0(in1[0]), .x1(in1[1]), .x2(in1[2]), .x3(in1[3]), .x4(in1[4]),
        .x0_o(out1[0]), .x1_o(out1[1]), .x2_o(out1[2]), .x3_o(out1[3]), .x4_o(out1[4]),
        .oBusy(busy1), .oDone(done1)
    );

    ascon_permutation #(.ROUNDS(12)) dut12 (
        .iClk(iClk), .iReset_n(iReset_n), .start(start12),
        .x0(in12[0]), .x1(in12[1]), .x2(in12[2]), .x3(in12[3]), .x4(in12[4]),
        .x0_o(out12[0]), .x1_o(out12[1]), .x2_o(out12[2]), .x3_o(out12[3]), .x4_o(out12[4]),
        .oBusy(busy12), .oDone(done12)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // bit-sliced reference: 5-bit S-box table lookup per column, linear layer bit by bit
    function automatic state_t perm(input state_t s, input int rounds);
        state_t     t;
        logic [4:0] o;
        for (int r = 12 - rounds; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int j = 0; j < 64; j++) begin
                o = SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
                {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]} = o;
            end
            for (int k = 0; k < 5; k++)
                for (int j = 0; j < 64; j++)
                    s[k][j] = t[k][j] ^ t[k][(j + RA[k]) % 64] ^ t[k][(j + RB[k]) % 64];
        end
        return s;
    endfunction

    localparam state_t VA = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBEEFCAFEBABE,
                             64'h0F1E2D3C4B5A6978, 64'h8000000000000001};
    localparam state_t VB = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                             64'h4444444444444444, 64'h5555555555555555};
    localparam state_t VC = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'h0000000000000000,
                             64'hFFFFFFFFFFFFFFFF, 64'h123456789ABCDEF0};
    localparam state_t VD = {64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 64'h1357913579135791,
                             64'h2468024680246802, 64'h7777777777777777};
    localparam state_t VE = {64'h0000000000000080, 64'h400C000000000000, 64'h0000000000000000,
                             64'h0001020304050607, 64'h08090A0B0C0D0E0F};
    localparam state_t VF = {64'hC0FFEE00C0FFEE00, 64'hBADF00DBADF00D00, 64'h0102030405060708,
                             64'h1020304050607080, 64'h9999999999999999};

    task automatic test_reset();
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out12[k] !== 64'h0) begin
                errors++;
                $display("FAIL reset_out12[%0d] got %h want 0", k, out12[k]);
            end
        end
        checks++;
        if ({busy1, done1, busy12, done12} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy1, done1, busy12, done12});
        end
        repeat (2) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
    endtask

    task automatic test_round1();
        // zero state, round 11 only: x2 gets 0x4B, every S-box column maps from 0 or 4
        state_t exp;
        exp = {64'h0, 64'h12E580000000004B, 64'h53FFFFFFFFFFFF90,
               64'h0000000096000213, 64'h000964B00000004B};
        in1 = '0;
        start1 = 1'b1;
        @(negedge iClk);
        checks++;
        if ({busy1, done1} !== 2'b10) begin
            errors++;
            $display("FAIL r1_run busy/done got %b want 10", {busy1, done1});
        end
        @(negedge iClk);
        checks++;
        if ({busy1, done1} !== 2'b01) begin
            errors++;
            $display("FAIL r1_done busy/done got %b want 01", {busy1, done1});
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out1[k] !== exp[k]) begin
                errors++;
                $display("FAIL r1_x%0d got %h want %h", k, out1[k], exp[k]);
            end
        end
        start1 = 1'b0;
        @(negedge iClk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL r1_idle done got %b want 0", done1);
        end
    endtask

    task automatic test_full();
        state_t exp;
        int busy = 0;
        int doneAt = 0;
        exp = perm(VA, 12);
        in12 = VA;
        start12 = 1'b1;
        for (int i = 1; i <= 30 && doneAt == 0; i++) begin
            @(negedge iClk);
            if (busy12) busy++;
            if (done12) doneAt = i;
        end
        checks++;
        if (busy != 12) begin
            errors++;
            $display("FAIL full_busy_cycles got %0d want 12", busy);
        end
        checks++;
        if (doneAt != 13) begin
            errors++;
            $display("FAIL full_done_edge got %0d want 13", doneAt);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out12[k] !== exp[k]) begin
                errors++;
                $display("FAIL full_x%0d got %h want %h", k, out12[k], exp[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checks++;
            if ({busy12, done12} !== 2'b01) begin
                errors++;
                $display("FAIL full_hold busy/done got %b want 01", {busy12, done12});
            end
        end
        start12 = 1'b0;
        @(negedge iClk);
        checks++;
        if ({busy12, done12} !== 2'b00) begin
            errors++;
            $display("FAIL full_idle busy/done got %b want 00", {busy12, done12});
        end
    endtask

    task automatic test_pulse();
        state_t exp;
        int doneCnt = 0;
        exp = perm(VB, 12);
        in12 = VB;
        start12 = 1'b1;
        @(negedge iClk);
        start12 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            if (done12) doneCnt++;
        end
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("FAIL pulse_done_cycles got %0d want 1", doneCnt);
        end
        checks++;
        if (out12 !== exp) begin
            errors++;
            $display("FAIL pulse_result got %h want %h", out12, exp);
        end
        checks++;
        if (busy12 !== 1'b0) begin
            errors++;
            $display("FAIL pulse_idle busy got %b want 0", busy12);
        end
    endtask

    task automatic test_ignore();
        state_t exp;
        int doneAt = 0;
        exp = perm(VC, 12);
        in12 = VC;
        start12 = 1'b1;
        repeat (3) @(negedge iClk);
        start12 = 1'b0;
        in12 = VD;
        @(negedge iClk);
        start12 = 1'b1;
        in12 = VF;
        for (int i = 1; i <= 20 && doneAt == 0; i++) begin
            @(negedge iClk);
            if (done12) doneAt = i;
        end
        checks++;
        if (doneAt != 9) begin
            errors++;
            $display("FAIL ignore_done_edge got %0d want 9", doneAt);
        end
        checks++;
        if (out12 !== exp) begin
            errors++;
            $display("FAIL ignore_result got %h want %h", out12, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checks++;
            if ({busy12, done12} !== 2'b01) begin
                errors++;
                $display("FAIL ignore_no_relaunch busy/done got %b want 01", {busy12, done12});
            end
        end
        start12 = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_reset_mid();
        state_t exp;
        int busy = 0;
        int doneAt = 0;
        exp = perm(VE, 12);
        in12 = VE;
        start12 = 1'b1;
        repeat (5) @(negedge iClk);
        #2 iReset_n = 1'b0;
        #1;
        checks++;
        if (out12 !== '0) begin
            errors++;
            $display("FAIL rstmid_out got %h want 0", out12);
        end
        checks++;
        if ({busy12, done12} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_flags busy/done got %b want 00", {busy12, done12});
        end
        @(negedge iClk);
        iReset_n = 1'b1;
        for (int i = 1; i <= 30 && doneAt == 0; i++) begin
            @(negedge iClk);
            if (busy12) busy++;
            if (done12) doneAt = i;
        end
        checks++;
        if (busy != 12 || doneAt != 13) begin
            errors++;
            $display("FAIL rstmid_relaunch busy %0d done_edge %0d want 12 13", busy, doneAt);
        end
        checks++;
        if (out12 !== exp) begin
            errors++;
            $display("FAIL rstmid_result got %h want %h", out12, exp);
        end
    endtask

    task automatic test_back_to_back();
        state_t oldRes, exp;
        int doneAt = 0;
        oldRes = perm(VE, 12);
        exp = perm(VF, 12);
        start12 = 1'b0;
        @(negedge iClk);
        checks++;
        if (done12 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop done got %b want 0", done12);
        end
        in12 = VF;
        start12 = 1'b1;
        for (int i = 1; i <= 20 && doneAt == 0; i++) begin
            @(negedge iClk);
            if (done12) doneAt = i;
            else begin
                checks++;
                if (out12 !== oldRes) begin
                    errors++;
                    $display("FAIL b2b_hold cycle %0d got %h want %h", i, out12, oldRes);
                end
            end
        end
        checks++;
        if (doneAt != 13) begin
            errors++;
            $display("FAIL b2b_done_edge got %0d want 13", doneAt);
        end
        checks++;
        if (out12 !== exp) begin
            errors++;
            $display("FAIL b2b_result got %h want %h", out12, exp);
        end
        start12 = 1'b0;
        @(negedge iClk);
    endtask

    initial begin
        iReset_n = 1'b0;
        start1 = 1'b0;
        start12 = 1'b0;
        in1 = '0;
        in12 = '0;
        test_reset();
        test_round1();
        test_full();
        test_pulse();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
